// File: rtl/debug_abstract_cmd_encoder.sv
// Turns debug-module abstract access-register commands into a stream of RV32 CSR/EBREAK words.
// Define DEBUG_CSR_ACCESS_EN to add CSR-register access through the DSCRATCH1-saved temp GPR.
module debug_abstract_cmd_encoder #(
    parameter logic [11:0] DSCRATCH0_ADDR = 12'h7B2
`ifdef DEBUG_CSR_ACCESS_EN
   ,parameter logic [11:0] DSCRATCH1_ADDR = 12'h7B3,
    parameter logic [4:0]  TEMP_REG       = 5'd8
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_regno,
    input  logic        cmd_write,
    input  logic        cmd_transfer,
    input  logic        cmd_postexec,
    input  logic [2:0]  cmd_aarsize,
    input  logic        abort,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        progbuf_start,
    output logic        done,
    output logic [2:0]  cmderr
);
    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [2:0]  FN3_RW     = 3'b001;
    localparam logic [2:0]  FN3_RS     = 3'b010;
    localparam logic [31:0] EBREAK     = 32'h0010_0073;
`ifdef DEBUG_CSR_ACCESS_EN
    localparam int AW = 12;
`else
    localparam int AW = 5;
`endif

    typedef enum logic [1:0] {IDLE, EMIT, FINISH} state_t;

    function automatic logic [31:0] sys(input logic [2:0] fn3, input logic [11:0] csr,
                                        input logic [4:0] rs1, input logic [4:0] rd);
        return {csr, rs1, fn3, rd, OPC_SYSTEM};
    endfunction

    // Word at position 'step'; positions at or past the access count are the EBREAK terminator.
    function automatic logic [31:0] word_at(input logic [2:0] step, input logic [2:0] nacc,
                                            input logic wr, input logic is_csr,
                                            input logic [AW-1:0] addr);
        logic [31:0] w;
        w = EBREAK;
        if (step < nacc) begin
            if (!is_csr)
                w = wr ? sys(FN3_RS, DSCRATCH0_ADDR, 5'd0, addr[4:0])
                       : sys(FN3_RW, DSCRATCH0_ADDR, addr[4:0], 5'd0);
`ifdef DEBUG_CSR_ACCESS_EN
            else begin
                case (step[1:0])
                    2'd0:    w = sys(FN3_RW, DSCRATCH1_ADDR, TEMP_REG, 5'd0);
                    2'd1:    w = sys(FN3_RS, wr ? DSCRATCH0_ADDR : addr, 5'd0, TEMP_REG);
                    2'd2:    w = sys(FN3_RW, wr ? addr : DSCRATCH0_ADDR, TEMP_REG, 5'd0);
                    default: w = sys(FN3_RS, DSCRATCH1_ADDR, 5'd0, TEMP_REG);
                endcase
            end
`endif
        end
        return w;
    endfunction

    state_t          state_q;
    logic [2:0]      step_q, nacc_q, last_q;
    logic            wr_q, post_q, csr_q;
    logic [AW-1:0]   addr_q;
    logic            ready_q, valid_q, prog_q, done_q;
    logic [31:0]     instr_q;
    logic [2:0]      err_q;

    logic            acc_gpr, acc_csr, acc_illegal;
    logic [2:0]      acc_nacc, acc_last, step_d;
    logic [AW-1:0]   acc_addr;
    logic [31:0]     first_word, next_word;

    always_comb begin
        acc_gpr = (cmd_regno[15:5] == 11'h080);
`ifdef DEBUG_CSR_ACCESS_EN
        acc_csr  = (cmd_regno[15:12] == 4'h0);
        acc_addr = cmd_regno[11:0];
`else
        acc_csr  = 1'b0;
        acc_addr = cmd_regno[4:0];
`endif
        acc_illegal = (cmd_aarsize != 3'd2) || (cmd_transfer && !acc_gpr && !acc_csr);
        acc_nacc    = !cmd_transfer ? 3'd0 : (acc_csr ? 3'd4 : 3'd1);
        acc_last    = acc_nacc + {2'b00, !cmd_postexec} - 3'd1;
        step_d      = step_q + 3'd1;
        first_word  = word_at(3'd0, acc_nacc, cmd_write, acc_csr, acc_addr);
        next_word   = word_at(step_d, nacc_q, wr_q, csr_q, addr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= 3'd0;
            nacc_q  <= 3'd0;
            last_q  <= 3'd0;
            wr_q    <= 1'b0;
            post_q  <= 1'b0;
            csr_q   <= 1'b0;
            addr_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            prog_q  <= 1'b0;
            done_q  <= 1'b0;
            instr_q <= 32'd0;
            err_q   <= 3'd0;
        end else begin
            prog_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    ready_q <= 1'b0;
                    step_q  <= 3'd0;
                    nacc_q  <= acc_nacc;
                    last_q  <= acc_last;
                    wr_q    <= cmd_write;
                    post_q  <= cmd_postexec;
                    csr_q   <= acc_csr;
                    addr_q  <= acc_addr;
                    if (acc_illegal) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                        err_q   <= 3'd2;
                    end else if (acc_nacc == 3'd0 && cmd_postexec) begin
                        // Nothing to emit: hand straight over to the program buffer.
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                        prog_q  <= 1'b1;
                        err_q   <= 3'd0;
                    end else begin
                        state_q <= EMIT;
                        valid_q <= 1'b1;
                        instr_q <= first_word;
                        err_q   <= 3'd0;
                    end
                end
                EMIT: if (abort) begin
                    state_q <= FINISH;
                    valid_q <= 1'b0;
                    done_q  <= 1'b1;
                    err_q   <= 3'd4;
                end else if (instr_ready) begin
                    if (step_q == last_q) begin
                        state_q <= FINISH;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        prog_q  <= post_q;
                        err_q   <= 3'd0;
                    end else begin
                        step_q  <= step_d;
                        instr_q <= next_word;
                    end
                end
                // done is already pulsing here, so a late abort has nothing left to cancel.
                FINISH: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready     = ready_q;
    assign instr         = instr_q;
    assign instr_valid   = valid_q;
    assign progbuf_start = prog_q;
    assign done          = done_q;
    assign cmderr        = err_q;
endmodule

// File: tb/tb_debug_abstract_cmd_encoder.sv
// Bench for debug_abstract_cmd_encoder: directed commands checked every cycle against a word-list model.
module tb_debug_abstract_cmd_encoder;
`ifdef DEBUG_CSR_ACCESS_EN
    localparam bit CSR_EN = 1'b1;
`else
    localparam bit CSR_EN = 1'b0;
`endif
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [15:0] cmd_regno = 16'd0;
    logic        cmd_write = 1'b0, cmd_transfer = 1'b0, cmd_postexec = 1'b0;
    logic [2:0]  cmd_aarsize = 3'd2;
    logic        abort = 1'b0;
    logic [31:0] instr;
    logic        instr_valid, instr_ready = 1'b1;
    logic        progbuf_start, done;
    logic [2:0]  cmderr;

    debug_abstract_cmd_encoder dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_regno(cmd_regno), .cmd_write(cmd_write), .cmd_transfer(cmd_transfer),
        .cmd_postexec(cmd_postexec), .cmd_aarsize(cmd_aarsize), .abort(abort),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .progbuf_start(progbuf_start), .done(done), .cmderr(cmderr)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Model: expected word list, error code and program-buffer handoff for one command.
    logic [31:0] b_q[$];
    logic        b_ill, b_prog;
    function automatic logic [31:0] enc(input int csr, input int rs1, input int fn3, input int rd);
        return (csr << 20) + (rs1 << 15) + (fn3 << 12) + (rd << 7) + 32'h73;
    endfunction
    task automatic build(input logic [15:0] rg, input logic wr, input logic tr, input logic pe,
                         input logic [2:0] sz);
        int r;
        bit is_gpr, is_csr;
        r = int'(rg);
        is_gpr = (r >= 'h1000) && (r <= 'h101F);
        is_csr = (r <= 'h0FFF) && CSR_EN;
        b_q.delete();
        b_prog = pe;
        b_ill = (sz != 3'd2) || (tr && !is_gpr && !is_csr);
        if (b_ill) return;
        if (tr && is_gpr) begin
            if (wr) b_q.push_back(enc('h7B2, 0, 2, r - 'h1000));
            else    b_q.push_back(enc('h7B2, r - 'h1000, 1, 0));
        end else if (tr) begin
            b_q.push_back(enc('h7B3, 8, 1, 0));
            if (wr) begin b_q.push_back(enc('h7B2, 0, 2, 8)); b_q.push_back(enc(r, 8, 1, 0)); end
            else    begin b_q.push_back(enc(r, 0, 2, 8));     b_q.push_back(enc('h7B2, 8, 1, 0)); end
            b_q.push_back(enc('h7B3, 0, 2, 8));
        end
        if (!pe) b_q.push_back(EBRK);
    endtask

    // Cycle compare: phase 0 idle, 1 emitting, 2 done-pulse cycle.
    bit          en_chk = 1'b0, rst_chk = 1'b1, pend_done = 1'b0, pend_prog = 1'b0, cur_prog = 1'b0;
    int          phase = 0;
    logic [2:0]  pend_err = 3'd0;
    logic [31:0] exp_q[$];
    always @(negedge clk) if (en_chk) begin
        chk("cmd_ready", cmd_ready, phase == 0);
        chk("instr_valid", instr_valid, phase == 1);
        chk("done", done, pend_done);
        chk("progbuf_start", progbuf_start, pend_prog);
        if (pend_done) chk("cmderr", cmderr, pend_err);
        if (phase == 1 && exp_q.size() > 0) chk("instr", instr, exp_q[0]);
        if (rst_chk) begin chk("rst_instr", instr, 0); chk("rst_cmderr", cmderr, 0); end
        pend_done = 1'b0; pend_prog = 1'b0; rst_chk = 1'b0;
        if (rst) begin
            phase = 0; exp_q.delete(); rst_chk = 1'b1;
        end else case (phase)
            0: if (cmd_valid) begin
                build(cmd_regno, cmd_write, cmd_transfer, cmd_postexec, cmd_aarsize);
                exp_q = b_q; cur_prog = b_prog;
                if (b_ill) begin pend_done = 1'b1; pend_err = 3'd2; phase = 2; end
                else if (exp_q.size() == 0) begin
                    pend_done = 1'b1; pend_err = 3'd0; pend_prog = 1'b1; phase = 2;
                end else phase = 1;
            end
            1: if (abort) begin
                exp_q.delete(); pend_done = 1'b1; pend_err = 3'd4; phase = 2;
            end else if (instr_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    pend_done = 1'b1; pend_err = 3'd0; pend_prog = cur_prog; phase = 2;
                end
            end
            default: phase = 0;
        endcase
    end

    // Issue one command; stall/abort/reset on 0-based word indices (-1 = never).
    task automatic run_cmd(input logic [15:0] rg, input logic wr, input logic tr, input logic pe,
                           input logic [2:0] sz, input int stall_w, input int stall_n,
                           input int abort_w, input int rst_w);
        int w, n, stalled;
        bit hs;
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        cmd_regno = rg; cmd_write = wr; cmd_transfer = tr; cmd_postexec = pe; cmd_aarsize = sz;
        cmd_valid = 1'b1; instr_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        w = 0; n = 0; stalled = 0;
        while (!done && n < 100) begin
            if (w == rst_w && instr_valid) begin
                rst = 1'b1; @(posedge clk); #1; rst = 1'b0; return;
            end
            abort = (w == abort_w);
            instr_ready = !(w == stall_w && stalled < stall_n);
            if (!instr_ready) stalled++;
            hs = instr_valid && instr_ready && !abort;
            @(posedge clk); #1;
            abort = 1'b0; instr_ready = 1'b1;
            if (hs) w++;
            n++;
        end
        if (n >= 100) begin
            n_chk++;
            $display("FAIL timeout: no done after %0d cycles, expected done for regno %h", n, rg);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        // Pin the model to hand-computed words.
        build(16'h1005, 1'b0, 1'b1, 1'b0, 3'd2);
        chk("pin_gpr_rd_len", b_q.size(), 2);
        chk("pin_gpr_rd_w0", b_q[0], 32'h7B22_9073);
        chk("pin_gpr_rd_w1", b_q[1], 32'h0010_0073);
        build(16'h100A, 1'b1, 1'b1, 1'b1, 3'd2);
        chk("pin_gpr_wr_len", b_q.size(), 1);
        chk("pin_gpr_wr_w0", b_q[0], 32'h7B20_2573);
        chk("pin_gpr_wr_prog", b_prog, 1);
        build(16'h0300, 1'b0, 1'b1, 1'b0, 3'd2);
`ifdef DEBUG_CSR_ACCESS_EN
        chk("pin_csr_len", b_q.size(), 5);
        chk("pin_csr_w0", b_q[0], 32'h7B34_1073);
        chk("pin_csr_w1", b_q[1], 32'h3000_2473);
        chk("pin_csr_w2", b_q[2], 32'h7B24_1073);
        chk("pin_csr_w3", b_q[3], 32'h7B30_2473);
        chk("pin_csr_w4", b_q[4], 32'h0010_0073);
`else
        chk("pin_csr_ill", b_ill, 1);
`endif
        build(16'h1005, 1'b0, 1'b1, 1'b0, 3'd3);
        chk("pin_size_ill", b_ill, 1);
        build(16'h1020, 1'b0, 1'b1, 1'b0, 3'd2);
        chk("pin_range_ill", b_ill, 1);

        @(posedge clk); #1; en_chk = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        run_cmd(16'h1005, 1'b0, 1'b1, 1'b0, 3'd2, -1, 0, -1, -1);  // GPR read x5
        run_cmd(16'h100A, 1'b1, 1'b1, 1'b1, 3'd2, -1, 0, -1, -1);  // GPR write x10, postexec
        run_cmd(16'h0300, 1'b0, 1'b1, 1'b0, 3'd2, -1, 0, -1, -1);  // CSR read
        run_cmd(16'h1005, 1'b0, 1'b1, 1'b0, 3'd3, -1, 0, -1, -1);  // bad size
        run_cmd(16'h1020, 1'b0, 1'b1, 1'b0, 3'd2, -1, 0, -1, -1);  // bad regno
        run_cmd(16'h0305, 1'b1, 1'b1, 1'b0, 3'd2, 1, 3, 2, -1);    // CSR write: stall w1, abort w2
        run_cmd(16'h1007, 1'b0, 1'b1, 1'b0, 3'd2, 1, 3, -1, -1);   // GPR read, stall on EBREAK
        run_cmd(16'h1003, 1'b1, 1'b1, 1'b0, 3'd2, -1, 0, 1, -1);   // abort on EBREAK
        run_cmd(16'h0000, 1'b0, 1'b0, 1'b1, 3'd2, -1, 0, -1, -1);  // no transfer, postexec
        run_cmd(16'hFFFF, 1'b0, 1'b0, 1'b0, 3'd2, -1, 0, -1, -1);  // no transfer, EBREAK only
        run_cmd(16'h1000, 1'b1, 1'b1, 1'b0, 3'd2, -1, 0, -1, -1);  // write x0
        abort = 1'b1; @(posedge clk); #1; abort = 1'b0;            // abort while idle
        @(posedge clk); #1;
        run_cmd(16'h0341, 1'b0, 1'b1, 1'b0, 3'd2, -1, 0, -1, 2);   // reset mid CSR read
        @(posedge clk); #1;
        run_cmd(16'h1001, 1'b0, 1'b1, 1'b0, 3'd2, -1, 0, -1, 1);   // reset mid GPR read
        @(posedge clk); #1;
        run_cmd(16'h101F, 1'b0, 1'b1, 1'b0, 3'd2, -1, 0, -1, -1);  // fresh GPR read x31
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
